// File: rtl/program_loader_pkg.sv
// Shared types, sizing constants and small decode helpers for the program loader.
package program_loader_pkg;

  localparam int         DEPTH = 32;      // instruction words held
  localparam int         AW    = 5;       // log2(DEPTH)
  localparam logic [7:0] NOP   = 8'h00;   // word served when nothing valid can be fetched

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4
  } state_t;

  // True in the states that take bytes from the load stream.
  function automatic logic f_is_loading(input state_t s);
    return (s == HEADER) || (s == LOAD) || (s == CHECK);
  endfunction

  // A length byte is usable when it is non-zero and fits in the RAM.
  // Compared at 9 bits so a DEPTH of 256 would still work.
  function automatic logic f_len_ok(input logic [7:0] l);
    return (l != 8'd0) && ({1'b0, l} <= 9'(DEPTH));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Fetch bus, byte-wide load stream and status lines between host/CPU and the loader.
interface program_loader_if;

  logic [7:0] instruction_address;
  logic [7:0] instruction;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       cpu_reset;
  logic       loading;
  logic       load_error;
  logic [7:0] load_count;

  // Loader side.
  modport slave (
    input  instruction_address, load_start, load_valid, load_data,
    output instruction, load_ready, cpu_reset, loading, load_error, load_count
  );

  // Host / CPU side.
  modport master (
    output instruction_address, load_start, load_valid, load_data,
    input  instruction, load_ready, cpu_reset, loading, load_error, load_count
  );

endinterface

// File: rtl/program_loader_instr_ram.sv
// Instruction RAM: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
import program_loader_pkg::NOP;

module instr_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Write port: store the accepted program byte.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered word, NOP when disabled or colliding with a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= NOP;
    end else if (i_re && !(i_we && (i_waddr == i_raddr))) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= NOP;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/program_loader.sv
// Program loader: downloads a length-prefixed, checksummed program into
// instruction RAM, holds the CPU in reset while loading, then serves fetches.
import program_loader_pkg::*;

module program_loader (
  input  logic             oscillator,
  input  logic             reset,
  program_loader_if.slave  bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_len;
  logic [7:0] r_count;
  logic [7:0] r_sum;
  logic       r_load_error;
  logic       r_cpu_reset;
  logic       r_load_ready;
  logic       r_loading;

  logic       w_accept;
  logic       w_start_dl;
  logic       w_we;
  logic       w_rd_en;
  logic [7:0] w_rdata;

  // r_load_ready always equals the state decode, so this is valid && ready.
  assign w_accept   = bus.load_valid && r_load_ready;
  assign w_start_dl = bus.load_start && ((r_state == IDLE) || (r_state == RUN));
  assign w_we       = (r_state == LOAD) && w_accept;
  // len never exceeds DEPTH, so addr < len also rules out addr >= DEPTH.
  assign w_rd_en    = (r_state == RUN) && (bus.instruction_address < r_len);

  // Next-state decode for the download sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.load_start) w_next_state = HEADER;
        else                w_next_state = IDLE;
      end
      HEADER: begin
        if (w_accept) begin
          if (f_len_ok(bus.load_data)) w_next_state = LOAD;
          else                         w_next_state = IDLE;
        end else begin
          w_next_state = HEADER;
        end
      end
      LOAD: begin
        if (w_accept && (r_count == (r_len - 8'd1))) w_next_state = CHECK;
        else                                         w_next_state = LOAD;
      end
      CHECK: begin
        if (w_accept) begin
          if (bus.load_data == r_sum) w_next_state = RUN;
          else                        w_next_state = IDLE;
        end else begin
          w_next_state = CHECK;
        end
      end
      RUN: begin
        if (bus.load_start) w_next_state = HEADER;
        else                w_next_state = RUN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cpu_reset  <= 1'b1;
      r_load_ready <= 1'b0;
      r_loading    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cpu_reset  <= (w_next_state != RUN);
      r_load_ready <= f_is_loading(w_next_state);
      r_loading    <= f_is_loading(w_next_state);
    end
  end

  // Download bookkeeping: length, byte count, running checksum, sticky error.
  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) begin
      r_len        <= 8'd0;
      r_count      <= 8'd0;
      r_sum        <= 8'd0;
      r_load_error <= 1'b0;
    end else if (w_start_dl) begin
      r_count      <= 8'd0;
      r_sum        <= 8'd0;
      r_load_error <= 1'b0;
    end else if ((r_state == HEADER) && w_accept) begin
      if (f_len_ok(bus.load_data)) r_len        <= bus.load_data;
      else                         r_load_error <= 1'b1;
    end else if (w_we) begin
      r_count <= r_count + 8'd1;
      r_sum   <= r_sum + bus.load_data;
    end else if ((r_state == CHECK) && w_accept && (bus.load_data != r_sum)) begin
      r_load_error <= 1'b1;
    end else begin
      r_count <= r_count;
    end
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (oscillator),
    .rst     (reset),
    .i_we    (w_we),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (bus.load_data),
    .i_re    (w_rd_en),
    .i_raddr (bus.instruction_address[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.instruction = w_rdata;
  assign bus.load_ready  = r_load_ready;
  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.loading     = r_loading;
  assign bus.load_error  = r_load_error;
  assign bus.load_count  = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: download scenarios and a fetch scoreboard.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  program_loader_if bus();

  program_loader dut (
    .oscillator (clk),
    .reset      (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_mem [256];
  logic [7:0] model_len = 8'd0;
  bit         model_run = 1'b0;

  logic [7:0] pq[$];     // program bytes for the next download
  logic [7:0] aq[$];     // fetch addresses for the next fetch burst
  logic [7:0] exp_q[$];  // expected fetch results

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    if (gap) begin
      bus.load_valid = 1'b0;
      bus.load_data  = 8'hFF;
      tick();
    end
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    waited = 0;
    while ((bus.load_ready !== 1'b1) && (waited < 20)) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (bus.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready: load_ready=%b expected 1", bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Length byte, the bytes in pq, then checksum (optionally corrupted).
  task automatic download(input bit do_start, input logic [7:0] len, input bit bad, input bit gap);
    logic [7:0] s;
    s = 8'd0;
    model_run = 1'b0;
    if (do_start) pulse_start();
    send_byte(len, gap);
    foreach (pq[i]) begin
      send_byte(pq[i], gap);
      model_mem[i] = pq[i];
      s = s + pq[i];
    end
    send_byte(bad ? (s + 8'd1) : s, gap);
    model_len = len;
    model_run = !bad;
    n_cmp++;
    if (bus.cpu_reset !== bad) begin
      n_bad++;
      $display("FAIL dl_cpu_reset: got %b expected %b", bus.cpu_reset, bad);
    end
    n_cmp++;
    if (bus.load_error !== bad) begin
      n_bad++;
      $display("FAIL dl_load_error: got %b expected %b", bus.load_error, bad);
    end
    n_cmp++;
    if (bus.load_count !== len) begin
      n_bad++;
      $display("FAIL dl_load_count: got %h expected %h", bus.load_count, len);
    end
    n_cmp++;
    if (bus.loading !== 1'b0) begin
      n_bad++;
      $display("FAIL dl_loading: got %b expected 0", bus.loading);
    end
  endtask

  // Back-to-back fetches, one address per cycle, scoreboard checked a cycle later.
  task automatic fetch_check(input string tag);
    logic [7:0] e;
    foreach (aq[i]) begin
      bus.instruction_address = aq[i];
      exp_q.push_back((model_run && (aq[i] < model_len)) ? model_mem[aq[i]] : 8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instruction !== e) begin
        n_bad++;
        $display("FAIL %s addr %h: instruction=%h expected %h", tag, aq[i], bus.instruction, e);
      end
    end
  endtask

  task automatic test_reset();
    bus.instruction_address = 8'd0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset: got %b expected 1", bus.cpu_reset); end
    n_cmp++; if (bus.instruction !== 8'h00) begin n_bad++; $display("FAIL rst_instruction: got %h expected 00", bus.instruction); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL rst_load_ready: got %b expected 0", bus.load_ready); end
    n_cmp++; if (bus.load_error !== 1'b0) begin n_bad++; $display("FAIL rst_load_error: got %b expected 0", bus.load_error); end
    n_cmp++; if (bus.loading !== 1'b0) begin n_bad++; $display("FAIL rst_loading: got %b expected 0", bus.loading); end
    n_cmp++; if (bus.load_count !== 8'd0) begin n_bad++; $display("FAIL rst_load_count: got %h expected 00", bus.load_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_download();
    pulse_start();
    n_cmp++; if (bus.loading !== 1'b1) begin n_bad++; $display("FAIL good_loading: got %b expected 1", bus.loading); end
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_bad++; $display("FAIL good_ready: got %b expected 1", bus.load_ready); end
    pq = '{8'h41, 8'h82, 8'hC1};
    download(1'b0, 8'd3, 1'b0, 1'b0);
    aq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255, 8'd32, 8'd0};
    fetch_check("good_fetch");
  endtask

  task automatic test_bad_checksum();
    pq = '{8'h41, 8'h82, 8'hC1};
    download(1'b1, 8'd3, 1'b1, 1'b0);
    aq = '{8'd0, 8'd1};
    fetch_check("badchk_fetch");
  endtask

  task automatic test_bad_length();
    logic [7:0] lens [2];
    lens[0] = 8'h00;
    lens[1] = 8'h21;
    for (int k = 0; k < 2; k++) begin
      model_run = 1'b0;
      pulse_start();
      send_byte(lens[k], 1'b0);
      n_cmp++; if (bus.load_error !== 1'b1) begin n_bad++; $display("FAIL badlen_error len=%h: got %b expected 1", lens[k], bus.load_error); end
      n_cmp++; if (bus.loading !== 1'b0) begin n_bad++; $display("FAIL badlen_loading len=%h: got %b expected 0", lens[k], bus.loading); end
      n_cmp++; if (bus.load_count !== 8'd0) begin n_bad++; $display("FAIL badlen_count len=%h: got %h expected 00", lens[k], bus.load_count); end
      n_cmp++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL badlen_cpu_reset len=%h: got %b expected 1", lens[k], bus.cpu_reset); end
    end
    aq = '{8'd0};
    fetch_check("badlen_fetch");
  endtask

  task automatic test_valid_toggle();
    pq = '{8'hF0, 8'h80, 8'h9F, 8'h33, 8'hC5};
    download(1'b1, 8'd5, 1'b0, 1'b1);
    aq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd31};
    fetch_check("toggle_fetch");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'd4, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL midrst_cpu_reset: got %b expected 1", bus.cpu_reset); end
    n_cmp++; if (bus.loading !== 1'b0) begin n_bad++; $display("FAIL midrst_loading: got %b expected 0", bus.loading); end
    n_cmp++; if (bus.load_count !== 8'd0) begin n_bad++; $display("FAIL midrst_count: got %h expected 00", bus.load_count); end
    tick();
    rst = 1'b0;
    model_len = 8'd0;
    model_run = 1'b0;
    tick();
    pq = '{8'h5A};
    download(1'b1, 8'd1, 1'b0, 1'b0);
    aq = '{8'd0, 8'd1, 8'd2};
    fetch_check("midrst_fetch");
  endtask

  task automatic test_reload_collision();
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h02;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    model_run = 1'b0;
    n_cmp++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reload_cpu_reset: got %b expected 1", bus.cpu_reset); end
    n_cmp++; if (bus.loading !== 1'b1) begin n_bad++; $display("FAIL reload_loading: got %b expected 1", bus.loading); end
    n_cmp++; if (bus.load_count !== 8'd0) begin n_bad++; $display("FAIL reload_count: got %h expected 00", bus.load_count); end
    pq = '{8'h11, 8'h22};
    download(1'b0, 8'd2, 1'b0, 1'b0);
    aq = '{8'd0, 8'd1, 8'd2};
    fetch_check("reload_fetch");
  endtask

  initial begin
    test_reset();
    test_good_download();
    test_bad_checksum();
    test_bad_length();
    test_valid_toggle();
    test_reset_mid_load();
    test_reload_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
